// File: rtl/settings_bus_buffer_if.sv
// Settings bus buffer interface: write side, flush, and the valid/ready head
// port. The master modport is the producer/consumer side; slave is the buffer.
interface settings_bus_buffer_if #(
    parameter int DEPTH_LOG2 = 3
);
    logic                  set_stb;
    logic [7:0]            set_addr;
    logic [31:0]           set_data;
    logic                  clear;
    logic                  out_valid;
    logic                  out_ready;
    logic [7:0]            out_addr;
    logic [31:0]           out_data;
    logic [DEPTH_LOG2:0]   fill;
    logic                  overflow;

    modport master (
        output set_stb, set_addr, set_data, clear, out_ready,
        input  out_valid, out_addr, out_data, fill, overflow
    );

    modport slave (
        input  set_stb, set_addr, set_data, clear, out_ready,
        output out_valid, out_addr, out_data, fill, overflow
    );
endinterface

// File: rtl/settings_bus_buffer.sv
// FIFO of {addr, data} settings writes, 2^DEPTH_LOG2 deep, with sticky overflow.
// Ports: wb_clk, wb_rst_n (async low), bus (set_*/clear in; out_* head, fill, overflow).
module settings_bus_buffer #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                 wb_clk,
    input  logic                 wb_rst_n,
    settings_bus_buffer_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [39:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   fill_q;
    logic                  ovf_q;
    logic [39:0]           head;

    logic valid;
    logic full;
    logic pop;
    logic push;
    logic drop;

    assign valid = (fill_q != '0);
    // fill can only reach 2^DEPTH_LOG2 when full, so the top bit is "full"
    assign full  = fill_q[DEPTH_LOG2];
    assign pop   = valid & bus.out_ready & ~bus.clear;
    // a pop in the same cycle frees a slot, so a full queue still accepts
    assign push  = bus.set_stb & ~bus.clear & (~full | pop);
    assign drop  = bus.set_stb & ~bus.clear & ~push;

    always_ff @(posedge wb_clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.set_addr, bus.set_data};
        end
    end

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else if (bus.clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case (1'b1)
                (push & ~pop): fill_q <= fill_q + (DEPTH_LOG2+1)'(1);
                (pop & ~push): fill_q <= fill_q - (DEPTH_LOG2+1)'(1);
                default:       fill_q <= fill_q;
            endcase
            if (drop) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // outputs derive from pointers and fill only, so unreset storage is masked
    always_comb begin
        head = mem[rd_ptr];
    end

    assign bus.out_valid = valid;
    assign bus.out_addr  = valid ? head[39:32] : 8'h00;
    assign bus.out_data  = valid ? head[31:0] : 32'h0;
    assign bus.fill      = fill_q;
    assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_settings_bus_buffer.sv
// Directed testbench for settings_bus_buffer (depth 8).
// Ports: none; drives the DUT through settings_bus_buffer_if.
module tb_settings_bus_buffer;
    logic wb_clk;
    logic wb_rst_n;
    int   checks;
    int   failures;

    settings_bus_buffer_if #(.DEPTH_LOG2(3)) bus ();

    settings_bus_buffer #(.DEPTH_LOG2(3)) dut (
        .wb_clk   (wb_clk),
        .wb_rst_n (wb_rst_n),
        .bus      (bus)
    );

    initial wb_clk = 1'b0;
    always #5 wb_clk = ~wb_clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge wb_clk);
        @(negedge wb_clk);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.set_stb  = 1'b1;
        bus.set_addr = a;
        bus.set_data = d;
        tick();
        bus.set_stb  = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        wb_rst_n     = 1'b0;
        bus.set_stb  = 1'b0;
        bus.set_addr = 8'h00;
        bus.set_data = 32'h0;
        bus.clear    = 1'b0;
        bus.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_fill", 64'(bus.fill), 64'd0);
        chk("rst_ovf", 64'(bus.overflow), 64'd0);
        chk("rst_addr", 64'(bus.out_addr), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        wb_rst_n = 1'b1;

        // single write, no bypass in the push cycle
        bus.set_stb  = 1'b1;
        bus.set_addr = 8'h12;
        bus.set_data = 32'hDEADBEEF;
        #1;
        chk("no_bypass", 64'(bus.out_valid), 64'd0);
        tick();
        bus.set_stb = 1'b0;
        chk("sw_valid", 64'(bus.out_valid), 64'd1);
        chk("sw_addr", 64'(bus.out_addr), 64'h12);
        chk("sw_data", 64'(bus.out_data), 64'hDEADBEEF);
        chk("sw_fill", 64'(bus.fill), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("sw_hold", {bus.out_valid, bus.out_addr, bus.out_data},
                {24'h0, 1'b1, 8'h12, 32'hDEADBEEF});
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("sw_pop_fill", 64'(bus.fill), 64'd0);
        chk("sw_pop_valid", 64'(bus.out_valid), 64'd0);
        chk("sw_pop_out", {bus.out_addr, bus.out_data}, 64'd0);
        // ready on empty queue does nothing
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk("empty_pop_fill", 64'(bus.fill), 64'd0);

        // fill to 8 and overflow with a ninth write
        for (int i = 1; i <= 9; i++) begin
            wr(8'(i), 32'(i));
        end
        chk("ovf_fill", 64'(bus.fill), 64'd8);
        chk("ovf_flag", 64'(bus.overflow), 64'd1);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("ovf_drain", 64'(bus.out_data), 64'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("ovf_empty", 64'(bus.out_valid), 64'd0);
        chk("ovf_sticky", 64'(bus.overflow), 64'd1);
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        chk("ovf_cleared", 64'(bus.overflow), 64'd0);

        // full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) begin
            wr(8'(i), 32'(i));
        end
        chk("pp_full", 64'(bus.fill), 64'd8);
        bus.out_ready = 1'b1;
        wr(8'h09, 32'd9);
        bus.out_ready = 1'b0;
        chk("pp_fill", 64'(bus.fill), 64'd8);
        chk("pp_ovf", 64'(bus.overflow), 64'd0);
        bus.out_ready = 1'b1;
        for (int i = 2; i <= 9; i++) begin
            chk("pp_drain", 64'(bus.out_data), 64'(i));
            tick();
        end
        bus.out_ready = 1'b0;
        chk("pp_empty", 64'(bus.fill), 64'd0);

        // streaming across pointer wrap
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            wr(8'(i), 32'(100 + i));
            chk("st_data", 64'(bus.out_data), 64'(100 + i));
            chk("st_fill", 64'(bus.fill), 64'd1);
        end
        tick();
        bus.out_ready = 1'b0;
        chk("st_empty", 64'(bus.fill), 64'd0);

        // clear with write in the same cycle
        for (int i = 0; i < 5; i++) begin
            wr(8'hA0, 32'(i));
        end
        chk("clr_pre", 64'(bus.fill), 64'd5);
        bus.clear    = 1'b1;
        bus.set_stb  = 1'b1;
        bus.set_data = 32'h55;
        tick();
        bus.clear   = 1'b0;
        bus.set_stb = 1'b0;
        chk("clr_fill", 64'(bus.fill), 64'd0);
        chk("clr_valid", 64'(bus.out_valid), 64'd0);
        chk("clr_ovf", 64'(bus.overflow), 64'd0);
        tick();
        chk("clr_discard", 64'(bus.fill), 64'd0);

        // short async reset pulse with 3 entries queued
        for (int i = 0; i < 3; i++) begin
            wr(8'hB0, 32'(i + 7));
        end
        chk("rp_pre", 64'(bus.fill), 64'd3);
        #2;
        wb_rst_n = 1'b0;
        #1;
        chk("rp_valid", 64'(bus.out_valid), 64'd0);
        chk("rp_fill", 64'(bus.fill), 64'd0);
        chk("rp_out", {bus.out_addr, bus.out_data}, 64'd0);
        #2;
        wb_rst_n = 1'b1;
        tick();
        chk("rp_empty", 64'(bus.fill), 64'd0);
        wr(8'h3C, 32'hCAFEF00D);
        chk("rp_alive", {bus.out_addr, bus.out_data}, {24'h0, 8'h3C, 32'hCAFEF00D});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
